// File: rtl/dma_path_pkg.sv
// ============================================================================
// dma_path_pkg: opcodes, header layout and FSM encoding for dma_path_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package dma_path_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h03;

    localparam int HDR_LOCAL_LSB = 0;
    localparam int HDR_LOCAL_W   = 14;
    localparam int HDR_HOST_LSB  = 16;
    localparam int HDR_HOST_W    = 40;
    localparam int HDR_LEN_LSB   = 56;
    localparam int HDR_LEN_W     = 16;
    localparam int HDR_OP_LSB    = 72;
    localparam int HDR_OP_W      = 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GRANT = 3'd1;
    localparam logic [2:0] HDR   = 3'd2;
    localparam logic [2:0] ISSUE = 3'd3;
    localparam logic [2:0] WDATA = 3'd4;
    localparam logic [2:0] RDATA = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_GRANT = GRANT,
        ST_HDR   = HDR,
        ST_ISSUE = ISSUE,
        ST_WDATA = WDATA,
        ST_RDATA = RDATA,
        ST_DONE  = DONE
    } state_t;

    function automatic logic is_known_opcode(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_sync_fifo.sv
// ============================================================================
// dma_sync_fifo: single-clock FIFO with full/empty/count, async reset
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full     = (r_count == (AW+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Storage needs no reset: empty gates every read of stale entries.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_path_controller.sv
// ============================================================================
// dma_path_controller: header decode, host command issue, write FIFO, read pass-through
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_path_controller
    import dma_path_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         dma_req,
    output logic         dma_resp,
    input  logic         dma_write_valid,
    input  logic [127:0] dma_write_data,
    output logic         dma_write_ready,
    output logic         dma_read_valid,
    output logic [127:0] dma_read_data,
    input  logic         dma_read_ready,
    output logic         hc_cmd_valid,
    input  logic         hc_cmd_ready,
    output logic [7:0]   hc_cmd_opcode,
    output logic [39:0]  hc_cmd_host_addr,
    output logic [13:0]  hc_cmd_local_addr,
    output logic [15:0]  hc_cmd_length,
    output logic         hc_wr_valid,
    output logic [127:0] hc_wr_data,
    output logic         hc_wr_last,
    input  logic         hc_wr_ready,
    input  logic         hc_rd_valid,
    input  logic [127:0] hc_rd_data,
    output logic         hc_rd_ready,
    output logic         busy,
    output logic         err_bad_opcode
);

    state_t         r_state;
    state_t         w_next_state;
    logic [15:0]    r_in_cnt;
    logic [15:0]    r_out_cnt;
    logic [15:0]    r_rd_cnt;
    logic [15:0]    w_len_m1;
    logic [7:0]     w_hdr_op;
    logic           w_in_wdata;
    logic           w_in_rdata;
    logic           w_push;
    logic           w_pop;
    logic           w_rd_beat;
    logic           w_wr_room;
    logic           w_fifo_full;
    logic           w_fifo_empty;
    logic [127:0]   w_fifo_head;
    logic [FIFO_AW:0] w_fifo_count;
    logic           w_unused_fifo_count;

    assign w_hdr_op   = dma_write_data[HDR_OP_LSB +: HDR_OP_W];
    assign w_len_m1   = hc_cmd_length - 16'd1;
    assign w_in_wdata = (r_state == ST_WDATA);
    assign w_in_rdata = (r_state == ST_RDATA);
    assign busy       = (r_state != ST_IDLE);

    // Input side stops at the programmed length so surplus beats stay with the requester.
    assign w_wr_room  = !w_fifo_full && (r_in_cnt < hc_cmd_length);
    assign w_push     = w_in_wdata && dma_write_valid && dma_write_ready;
    assign w_pop      = hc_wr_valid && hc_wr_ready;

    assign hc_wr_valid = w_in_wdata && !w_fifo_empty;
    assign hc_wr_data  = hc_wr_valid ? w_fifo_head : '0;
    assign hc_wr_last  = hc_wr_valid && (r_out_cnt == w_len_m1);

    // Read data is a zero-latency pass-through, gated off outside the read phase.
    assign dma_read_valid = w_in_rdata && hc_rd_valid;
    assign dma_read_data  = w_in_rdata ? hc_rd_data : '0;
    assign hc_rd_ready    = w_in_rdata && dma_read_ready;
    assign w_rd_beat      = w_in_rdata && hc_rd_valid && dma_read_ready;

    assign w_unused_fifo_count = ^w_fifo_count;

    dma_sync_fifo #(
        .WIDTH (128),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (dma_write_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        dma_resp        = 1'b0;
        dma_write_ready = 1'b0;
        hc_cmd_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dma_req) begin
                    w_next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                dma_resp     = 1'b1;
                w_next_state = ST_HDR;
            end
            ST_HDR: begin
                dma_write_ready = 1'b1;
                if (dma_write_valid) begin
                    w_next_state = is_known_opcode(w_hdr_op) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                hc_cmd_valid = 1'b1;
                if (hc_cmd_ready) begin
                    if (hc_cmd_length == 16'd0) begin
                        w_next_state = ST_DONE;
                    end else if (hc_cmd_opcode == OP_WRITE) begin
                        w_next_state = ST_WDATA;
                    end else begin
                        w_next_state = ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                dma_write_ready = w_wr_room;
                if (w_pop && (r_out_cnt == w_len_m1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_RDATA: begin
                if (w_rd_beat && (r_rd_cnt == w_len_m1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_cmd_opcode     <= '0;
            hc_cmd_host_addr  <= '0;
            hc_cmd_local_addr <= '0;
            hc_cmd_length     <= '0;
            err_bad_opcode    <= 1'b0;
            r_in_cnt          <= '0;
            r_out_cnt         <= '0;
            r_rd_cnt          <= '0;
        end else begin
            if ((r_state == ST_HDR) && dma_write_valid) begin
                hc_cmd_opcode     <= w_hdr_op;
                hc_cmd_host_addr  <= dma_write_data[HDR_HOST_LSB +: HDR_HOST_W];
                hc_cmd_local_addr <= dma_write_data[HDR_LOCAL_LSB +: HDR_LOCAL_W];
                hc_cmd_length     <= dma_write_data[HDR_LEN_LSB +: HDR_LEN_W];
                if (!is_known_opcode(w_hdr_op)) begin
                    err_bad_opcode <= 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_in_cnt  <= '0;
                r_out_cnt <= '0;
                r_rd_cnt  <= '0;
            end else begin
                if (w_push) begin
                    r_in_cnt <= r_in_cnt + 16'd1;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt + 16'd1;
                end
                if (w_rd_beat) begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_path_controller.sv
// ============================================================================
// tb_dma_path_controller: randomized self-checking bench with a transaction-level model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dma_path_controller;

    localparam int DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         dma_req;
    logic         dma_resp;
    logic         dma_write_valid;
    logic [127:0] dma_write_data;
    logic         dma_write_ready;
    logic         dma_read_valid;
    logic [127:0] dma_read_data;
    logic         dma_read_ready;
    logic         hc_cmd_valid;
    logic         hc_cmd_ready;
    logic [7:0]   hc_cmd_opcode;
    logic [39:0]  hc_cmd_host_addr;
    logic [13:0]  hc_cmd_local_addr;
    logic [15:0]  hc_cmd_length;
    logic         hc_wr_valid;
    logic [127:0] hc_wr_data;
    logic         hc_wr_last;
    logic         hc_wr_ready;
    logic         hc_rd_valid;
    logic [127:0] hc_rd_data;
    logic         hc_rd_ready;
    logic         busy;
    logic         err_bad_opcode;

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dma_path_controller #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .dma_req           (dma_req),
        .dma_resp          (dma_resp),
        .dma_write_valid   (dma_write_valid),
        .dma_write_data    (dma_write_data),
        .dma_write_ready   (dma_write_ready),
        .dma_read_valid    (dma_read_valid),
        .dma_read_data     (dma_read_data),
        .dma_read_ready    (dma_read_ready),
        .hc_cmd_valid      (hc_cmd_valid),
        .hc_cmd_ready      (hc_cmd_ready),
        .hc_cmd_opcode     (hc_cmd_opcode),
        .hc_cmd_host_addr  (hc_cmd_host_addr),
        .hc_cmd_local_addr (hc_cmd_local_addr),
        .hc_cmd_length     (hc_cmd_length),
        .hc_wr_valid       (hc_wr_valid),
        .hc_wr_data        (hc_wr_data),
        .hc_wr_last        (hc_wr_last),
        .hc_wr_ready       (hc_wr_ready),
        .hc_rd_valid       (hc_rd_valid),
        .hc_rd_data        (hc_rd_data),
        .hc_rd_ready       (hc_rd_ready),
        .busy              (busy),
        .err_bad_opcode    (err_bad_opcode)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Header built from the documented field layout; ignored fields carry random junk.
    function automatic logic [127:0] make_hdr(input logic [7:0] op, input logic [15:0] len,
                                              input logic [39:0] host, input logic [13:0] loc);
        logic [127:0] h;
        h = rand128();
        h[13:0]  = loc;
        h[55:16] = host;
        h[71:56] = len;
        h[79:72] = op;
        return h;
    endfunction

    function automatic logic [342:0] all_outputs();
        return {dma_resp, dma_write_ready, dma_read_valid, dma_read_data, hc_cmd_valid,
                hc_cmd_opcode, hc_cmd_host_addr, hc_cmd_local_addr, hc_cmd_length,
                hc_wr_valid, hc_wr_data, hc_wr_last, hc_rd_ready, busy, err_bad_opcode};
    endfunction

    task automatic idle_inputs();
        dma_req = 0; dma_write_valid = 0; dma_write_data = '0; dma_read_ready = 0;
        hc_cmd_ready = 0; hc_wr_ready = 0; hc_rd_valid = 0; hc_rd_data = '0;
    endtask

    // Two cycles after completion: DONE (busy) then IDLE (not busy).
    task automatic check_tail(input string tag);
        @(negedge clk); idle_inputs(); hc_rd_valid = 1; #1;
        n_checks++;
        if (busy !== 1'b1 || hc_wr_valid !== 1'b0 || dma_read_valid !== 1'b0)
            $display("FAIL %s_done busy=%b wr_valid=%b rd_valid=%b exp 1/0/0", tag, busy, hc_wr_valid, dma_read_valid);
        else n_pass++;
        @(negedge clk); hc_rd_valid = 0; #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL %s_idle busy=%b exp 0", tag, busy); else n_pass++;
    endtask

    task automatic run_write(input int len, input logic [39:0] host, input logic [13:0] loc,
                             input int stall, input bit rnd, input int abort_at);
        logic [127:0] pay[$];
        logic [127:0] hdr;
        int cyc, sent, got, resp_cnt, cmd_cycle;
        bit granted, hdr_done, cmd_seen, exp_ready, exp_wv, exp_last;
        for (int i = 0; i < len; i++) pay.push_back(rand128());
        hdr = make_hdr(8'h03, 16'(len), host, loc);
        cyc = 0; sent = 0; got = 0; resp_cnt = 0; cmd_cycle = 0;
        granted = 0; hdr_done = 0; cmd_seen = 0;
        @(negedge clk); dma_req = 1;
        while (1) begin
            if (cyc > 3000) begin
                n_checks++; $display("FAIL write_timeout got=%0d exp=%0d beats", got, len);
                break;
            end
            if (abort_at >= 0 && cmd_seen && sent == abort_at) begin
                idle_inputs(); #1;
                n_checks++;
                if (busy !== 1'b1) $display("FAIL abort_busy got=%b exp=1", busy); else n_pass++;
                #1 rst = 1; #1;
                n_checks++;
                if (all_outputs() !== '0) $display("FAIL abort_outputs got=%h exp=0", all_outputs());
                else n_pass++;
                @(negedge clk); rst = 0;
                return;
            end
            dma_write_valid = granted && (!hdr_done || sent < len) && (!rnd || $urandom_range(0, 3) != 0);
            dma_write_data  = !hdr_done ? hdr : ((sent < len) ? pay[sent] : rand128());
            hc_cmd_ready    = !rnd || $urandom_range(0, 1) == 1;
            hc_wr_ready     = cmd_seen && (cyc - cmd_cycle > stall) && (!rnd || $urandom_range(0, 2) != 0);
            #1;
            if (!granted) exp_ready = 0;
            else if (!hdr_done) exp_ready = 1;
            else if (!cmd_seen) exp_ready = 0;
            else exp_ready = (sent - got < DEPTH) && (sent < len);
            exp_wv   = cmd_seen && (sent > got);
            exp_last = exp_wv && (got == len - 1);
            n_checks++;
            if (dma_write_ready !== exp_ready)
                $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, dma_write_ready, exp_ready);
            else n_pass++;
            n_checks++;
            if (hc_wr_valid !== exp_wv || hc_wr_last !== exp_last)
                $display("FAIL wr_valid_last cyc=%0d got=%b/%b exp=%b/%b", cyc, hc_wr_valid, hc_wr_last, exp_wv, exp_last);
            else n_pass++;
            n_checks++;
            if (hc_cmd_valid !== (hdr_done && !cmd_seen))
                $display("FAIL cmd_valid cyc=%0d got=%b exp=%b", cyc, hc_cmd_valid, hdr_done && !cmd_seen);
            else n_pass++;
            if (dma_resp) begin resp_cnt++; granted = 1; dma_req = 0; end
            if (hc_cmd_valid && hc_cmd_ready && !cmd_seen) begin
                n_checks++;
                if (hc_cmd_opcode !== 8'h03 || hc_cmd_length !== 16'(len) ||
                    hc_cmd_host_addr !== host || hc_cmd_local_addr !== loc)
                    $display("FAIL cmd_fields got=%h/%h/%h/%h exp=03/%h/%h/%h", hc_cmd_opcode,
                             hc_cmd_length, hc_cmd_host_addr, hc_cmd_local_addr, 16'(len), host, loc);
                else n_pass++;
                cmd_seen = 1; cmd_cycle = cyc;
            end
            if (dma_write_valid && dma_write_ready) begin
                if (!hdr_done) hdr_done = 1; else sent++;
            end
            if (hc_wr_valid && hc_wr_ready) begin
                n_checks++;
                if (got >= len || hc_wr_data !== pay[got])
                    $display("FAIL wr_data beat=%0d got=%h exp=%h", got, hc_wr_data, (got < len) ? pay[got] : '0);
                else n_pass++;
                got++;
            end
            cyc++;
            if (cmd_seen && got >= len) break;
            @(negedge clk);
        end
        n_checks++;
        if (resp_cnt !== 1) $display("FAIL resp_pulses got=%0d exp=1", resp_cnt); else n_pass++;
        check_tail("write");
    endtask

    task automatic run_read(input int len, input bit pattern);
        logic [127:0] dat[$];
        logic [127:0] hdr;
        logic [63:0]  r64;
        logic [39:0]  host;
        logic [13:0]  loc;
        logic [127:0] exp_data;
        int cyc, got, cmd_cycle, k;
        bit granted, hdr_done, cmd_seen, rd;
        for (int i = 0; i < len; i++) dat.push_back(rand128());
        r64 = {$urandom, $urandom}; host = r64[39:0]; loc = r64[63:50];
        hdr = make_hdr(8'h01, 16'(len), host, loc);
        cyc = 0; got = 0; cmd_cycle = 0; granted = 0; hdr_done = 0; cmd_seen = 0;
        @(negedge clk); dma_req = 1;
        while (1) begin
            if (cyc > 3000) begin
                n_checks++; $display("FAIL read_timeout got=%0d exp=%0d beats", got, len);
                break;
            end
            rd = cmd_seen && (got < len);
            k  = cyc - cmd_cycle - 1;
            dma_write_valid = granted && !hdr_done;
            dma_write_data  = hdr;
            hc_cmd_ready    = pattern || $urandom_range(0, 1) == 1;
            hc_rd_valid     = pattern ? 1'b1 : ($urandom_range(0, 2) != 0);
            hc_rd_data      = (got < len) ? dat[got] : rand128();
            dma_read_ready  = (pattern && rd) ? (k % 4 != 1) : ($urandom_range(0, 1) == 1);
            #1;
            exp_data = rd ? dat[got] : '0;
            n_checks++;
            if (dma_read_valid !== (rd && hc_rd_valid) || hc_rd_ready !== (rd && dma_read_ready))
                $display("FAIL rd_handshake cyc=%0d got=%b/%b exp=%b/%b", cyc, dma_read_valid, hc_rd_ready,
                         rd && hc_rd_valid, rd && dma_read_ready);
            else n_pass++;
            n_checks++;
            if (dma_read_data !== exp_data)
                $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, dma_read_data, exp_data);
            else n_pass++;
            n_checks++;
            if (hc_wr_valid !== 1'b0 || dma_write_ready !== (granted && !hdr_done))
                $display("FAIL rd_side_outputs cyc=%0d wr_valid=%b wr_ready=%b exp 0/%b", cyc, hc_wr_valid,
                         dma_write_ready, granted && !hdr_done);
            else n_pass++;
            if (dma_resp) begin granted = 1; dma_req = 0; end
            if (hc_cmd_valid && hc_cmd_ready && !cmd_seen) begin
                n_checks++;
                if (hc_cmd_opcode !== 8'h01 || hc_cmd_length !== 16'(len) || hc_cmd_host_addr !== host)
                    $display("FAIL rd_cmd_fields got=%h/%h/%h exp=01/%h/%h", hc_cmd_opcode, hc_cmd_length,
                             hc_cmd_host_addr, 16'(len), host);
                else n_pass++;
                cmd_seen = 1; cmd_cycle = cyc;
            end
            if (dma_write_valid && dma_write_ready) hdr_done = 1;
            if (rd && hc_rd_valid && dma_read_ready) got++;
            cyc++;
            if (cmd_seen && got >= len) break;
            @(negedge clk);
        end
        check_tail("read");
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); #1;
        n_checks++;
        if (all_outputs() !== '0) $display("FAIL reset_outputs got=%h exp=0", all_outputs()); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || err_bad_opcode !== 1'b0) $display("FAIL post_reset busy=%b err=%b exp 0/0", busy, err_bad_opcode);
        else n_pass++;
    endtask

    task automatic test_write_len4();
        run_write(4, 40'h12_3456_7800, 14'h0040, 0, 0, -1);
    endtask

    task automatic test_write_backpressure();
        run_write(20, 40'hAB_CDEF_0120, 14'h1234, 20, 0, -1);
    endtask

    task automatic test_read_toggle();
        run_read(3, 1);
    endtask

    task automatic test_random_traffic();
        logic [63:0] r64;
        for (int t = 0; t < 10; t++) begin
            r64 = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) run_write($urandom_range(1, 40), r64[39:0], r64[63:50], $urandom_range(0, 5), 1, -1);
            else run_read($urandom_range(1, 30), 0);
        end
    endtask

    task automatic test_bad_opcode();
        int cyc, post;
        bit granted, hdr_done;
        cyc = 0; post = 0; granted = 0; hdr_done = 0;
        @(negedge clk); dma_req = 1;
        while (1) begin
            if (cyc > 50) begin n_checks++; $display("FAIL badop_timeout cyc=%0d", cyc); break; end
            dma_write_valid = granted && !hdr_done;
            dma_write_data  = make_hdr(8'h07, 16'd5, 40'h1, 14'h2);
            hc_cmd_ready    = 1;
            #1;
            n_checks++;
            if (hc_cmd_valid !== 1'b0) $display("FAIL badop_cmd_valid cyc=%0d got=%b exp=0", cyc, hc_cmd_valid); else n_pass++;
            if (hdr_done) begin
                post++;
                n_checks++;
                if (err_bad_opcode !== 1'b1 || busy !== (post == 1))
                    $display("FAIL badop_state post=%0d err=%b busy=%b exp 1/%b", post, err_bad_opcode, busy, post == 1);
                else n_pass++;
                if (post == 2) break;
            end
            if (dma_resp) begin granted = 1; dma_req = 0; end
            if (dma_write_valid && dma_write_ready) hdr_done = 1;
            cyc++;
            @(negedge clk);
        end
        idle_inputs();
        run_write(3, 40'h00_0000_1000, 14'h0100, 0, 0, -1);
        n_checks++;
        if (err_bad_opcode !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err_bad_opcode); else n_pass++;
    endtask

    task automatic test_len0_write();
        run_write(0, 40'h55_0000_0000, 14'h0010, 0, 0, -1);
    endtask

    task automatic test_reset_mid_write();
        run_write(8, 40'h77_0000_0040, 14'h0200, 1000, 0, 2);
        run_write(2, 40'h66_0000_0080, 14'h0300, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_write_len4();
        test_write_backpressure();
        test_read_toggle();
        test_random_traffic();
        test_bad_opcode();
        test_len0_write();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout passed=%0d checks=%0d", n_pass, n_checks);
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/dma_path_controller.md
Name: dma_path_controller

Overview:
- Sits directly downstream of the FPU-core load/store controller. Terminates its dma_req/dma_resp handshake and its 128-bit command+data stream.
- Decodes the header beat into a host-DMA command.
- Writes: buffers payload beats in a FIFO toward the host DMA engine.
- Reads: streams host read data back to the requester.

Parameters:
- FIFO_DEPTH, 16, write-payload FIFO depth in 128-bit beats (power of two, >=2).
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dma_req  in  1  requester transaction request (level)
- dma_resp  out  1  one-cycle grant pulse
- dma_write_valid  in  1  requester beat valid
- dma_write_data  in  128  header or payload beat
- dma_write_ready  out  1  block can accept a beat
- dma_read_valid  out  1  read beat to requester valid
- dma_read_data  out  128  read beat
- dma_read_ready  in  1  requester accepts read beat
- hc_cmd_valid  out  1  host command valid
- hc_cmd_ready  in  1  host engine accepts command
- hc_cmd_opcode  out  8  0x01 read, 0x03 write
- hc_cmd_host_addr  out  40  host byte address
- hc_cmd_local_addr  out  14  local buffer address
- hc_cmd_length  out  16  beat count
- hc_wr_valid  out  1  write payload beat valid (FIFO not empty)
- hc_wr_data  out  128  FIFO head
- hc_wr_last  out  1  final payload beat
- hc_wr_ready  in  1  host engine accepts payload
- hc_rd_valid  in  1  host read beat valid
- hc_rd_data  in  128  host read beat
- hc_rd_ready  out  1  pass-through of requester ready
- busy  out  1  state != IDLE
- err_bad_opcode  out  1  sticky; cleared only by reset

Behaviour:
- Header beat fields:
  - [13:0] local_addr
  - [15:14] reserved (ignored)
  - [55:16] host_addr
  - [71:56] length
  - [79:72] opcode
  - [127:80] ignored
- Reset: every output 0; FIFO emptied; counters 0; state IDLE. Reset mid-transfer aborts the transfer silently, with no partial command or last flag.
- States:
  - IDLE: on dma_req=1 go GRANT.
  - GRANT: dma_resp=1 for exactly this cycle; go HDR.
  - HDR: dma_write_ready=1. On dma_write_valid, latch the header fields into the hc_cmd_* registers.
    - Opcode 0x01 or 0x03: go ISSUE.
    - Any other opcode: set err_bad_opcode, go DONE; no command is issued.
  - ISSUE: hc_cmd_valid=1, fields stable until hc_cmd_ready. On handshake:
    - length==0: go DONE.
    - opcode 0x03: go WDATA.
    - opcode 0x01: go RDATA.
  - WDATA:
    - Input side: dma_write_ready = !fifo_full && (in_cnt < length). Push on valid&&ready; in_cnt+1.
    - Output side: pop on hc_wr_valid&&hc_wr_ready; out_cnt+1. hc_wr_last = hc_wr_valid && (out_cnt == length-1).
    - Go DONE on the pop with out_cnt == length-1.
  - RDATA:
    - dma_read_valid = hc_rd_valid; dma_read_data = hc_rd_data; hc_rd_ready = dma_read_ready. Combinational pass-through, zero latency.
    - rd_cnt increments on hc_rd_valid&&dma_read_ready; go DONE on the beat with rd_cnt == length-1.
    - Outside RDATA: hc_rd_ready=0, dma_read_valid=0.
  - DONE: one cycle; clear counters; go IDLE. The next dma_req is sampled in IDLE, so the minimum gap between grants is 2 idle cycles.
- dma_write_ready=0 in every state except HDR and WDATA. Beats offered when ready is 0 are not consumed.
- Beats beyond length are never accepted.
- FIFO:
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Push when full is impossible (gated by ready); pop when empty is impossible (hc_wr_valid=0).
- Counters and length are 16-bit unsigned; max transfer 65535 beats; no wrap within one transfer.
- dma_req deasserted after the grant is ignored; the transfer runs to completion.

Decomposition:
- Package dma_path_pkg:
  - Opcode constants OP_READ=8'h01, OP_WRITE=8'h03.
  - Header bit-position constants.
  - State encoding localparams IDLE/GRANT/HDR/ISSUE/WDATA/RDATA/DONE.
- One sub-module: dma_sync_fifo (parameterised width/depth, full/empty/count, single clock, async reset). It is instantiated once for the write payload.

Test Plan:
- Write, length 4: header {opcode 0x03, length 4, host 0x12_3456_7800, local 0x0040}, then beats A0..A3 with hc ready always 1.
  - dma_resp pulses once.
  - hc_cmd carries exactly those fields.
  - hc_wr emits A0..A3 in order, with hc_wr_last only on A3.
  - busy falls 1 cycle after A3 pops.
- Write backpressure, length 20, FIFO_DEPTH 16, hc_wr_ready held 0 until 20 cycles after the command:
  - dma_write_ready drops after 16 pushes.
  - All 20 beats arrive intact once ready rises.
  - No beat is lost or duplicated.
- Read, length 3, host returns D0..D2 while dma_read_ready toggles 1,0,1,1:
  - dma_read_data equals D0..D2 in the same cycles.
  - hc_rd_ready mirrors dma_read_ready.
  - The FSM returns to IDLE after D2.
- Bad opcode 0x07:
  - hc_cmd_valid never asserts.
  - err_bad_opcode=1 and stays 1.
  - The next valid write transfer completes normally.
- Length 0 write: command is issued with length 0, no hc_wr_valid, then back to IDLE.
- Reset asserted mid-WDATA after 2 of 8 beats:
  - All outputs go 0 asynchronously.
  - After release, a fresh length-2 write completes with only the new beats, with no stale FIFO data.
